imm_encoder: RTL and testbench

Iterative immediate encoder for the decode-side immediate path: the inverse of the decode-stage immediate extender. It takes a 32-bit value and an ImmSrc class, searches for an instruction-field encoding that the extender would map back to that value, and returns the 24-bit Instr field with a success flag. The self-test instruction generator and boot-time patch logic use it to build legal data-processing, memory and branch immediates.

---
 rtl/imm_encoder.sv | 98 +++++++++
 tb/tb_imm_encoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: iterative search for an Instr[23:0] immediate field that the decode-stage extender maps back to a value
module imm_encoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_immsrc,
   input  logic [31:0] req_value,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [23:0] resp_field,
   output logic [1:0]  resp_immsrc,
   output logic        resp_ok
);

   typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;

   state_t      state_q;
   logic [31:0] value_q;
   logic [1:0]  class_q;
   logic [3:0]  r_q;
   logic        resp_valid_q;
   logic [23:0] resp_field_q;
   logic [1:0]  resp_immsrc_q;
   logic        resp_ok_q;

   logic [63:0] dbl_d;
   logic [31:0] rot_d;
   logic        hit_d;
   logic        unsigned_ok_d;
   logic        branch_ok_d;
   logic        done_d;
   logic        ok_d;
   logic [23:0] field_d;

   // Evaluate the current candidate: rotation r for class 00, a single check for the other classes
   always_comb begin
      dbl_d         = {value_q, value_q} << {r_q, 1'b0};
      rot_d         = dbl_d[63:32];
      hit_d         = rot_d[31:8] == 24'd0;
      unsigned_ok_d = value_q[31:12] == 20'd0;
      branch_ok_d   = (value_q[1:0] == 2'b00) && (value_q[31:26] == {6{value_q[25]}});
      done_d        = (class_q != 2'b00) || hit_d || (r_q == 4'd15);
      ok_d          = (class_q == 2'b00) ? hit_d :
                      (class_q == 2'b01) ? unsigned_ok_d :
                      (class_q == 2'b10) ? branch_ok_d : 1'b0;
      field_d       = !ok_d              ? 24'd0 :
                      (class_q == 2'b00) ? {12'd0, r_q, rot_d[7:0]} :
                      (class_q == 2'b01) ? {12'd0, value_q[11:0]} : value_q[25:2];
   end

   // Request/search/response sequencing with registered response outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         value_q       <= 32'd0;
         class_q       <= 2'b00;
         r_q           <= 4'd0;
         resp_valid_q  <= 1'b0;
         resp_field_q  <= 24'd0;
         resp_immsrc_q <= 2'b00;
         resp_ok_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (req_valid) begin
               value_q <= req_value;
               class_q <= req_immsrc;
               r_q     <= 4'd0;
               state_q <= SEARCH;
            end
            SEARCH: if (done_d) begin
               resp_valid_q  <= 1'b1;
               resp_field_q  <= field_d;
               resp_immsrc_q <= class_q;
               resp_ok_q     <= ok_d;
               state_q       <= RESP;
            end else begin
               r_q <= r_q + 4'd1;
            end
            RESP: if (resp_ready) begin
               resp_valid_q  <= 1'b0;
               resp_field_q  <= 24'd0;
               resp_immsrc_q <= 2'b00;
               resp_ok_q     <= 1'b0;
               state_q       <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready   = state_q == IDLE;
   assign resp_valid  = resp_valid_q;
   assign resp_field  = resp_field_q;
   assign resp_immsrc = resp_immsrc_q;
   assign resp_ok     = resp_ok_q;

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed scenario bench for the iterative immediate encoder
module tb_imm_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_immsrc;
   logic [31:0] req_value;
   logic        resp_valid;
   logic        resp_ready;
   logic [23:0] resp_field;
   logic [1:0]  resp_immsrc;
   logic        resp_ok;

   int checks = 0;
   int errors = 0;

   imm_encoder dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_immsrc  (req_immsrc),
      .req_value   (req_value),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_field  (resp_field),
      .resp_immsrc (resp_immsrc),
      .resp_ok     (resp_ok)
   );

   always #5 clk = ~clk;

   // Accept one request (called at #1 after an edge, in IDLE) and return the edge count until resp_valid
   task automatic do_req(input logic [1:0] cls, input logic [31:0] val, output int lat);
      req_valid  = 1'b1;
      req_immsrc = cls;
      req_value  = val;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_immsrc = ~cls;
      req_value  = ~val;
      lat = 0;
      while (!resp_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic take_resp();
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", resp_valid); end
      checks++;
      if (resp_field !== 24'd0) begin errors++; $display("FAIL reset_field got %h want 000000", resp_field); end
      checks++;
      if (resp_ok !== 1'b0) begin errors++; $display("FAIL reset_ok got %b want 0", resp_ok); end
      checks++;
      if (resp_immsrc !== 2'b00) begin errors++; $display("FAIL reset_immsrc got %b want 00", resp_immsrc); end
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
   endtask

   task automatic test_rotated();
      logic [31:0] vals [5] = '{32'h0000_00FF, 32'hFF00_0000, 32'h0000_0101, 32'h0000_03FC, 32'h0000_0000};
      logic [23:0] flds [5] = '{24'h0000FF, 24'h0004FF, 24'h000000, 24'h000FFF, 24'h000000};
      logic        oks  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      int          lats [5] = '{1, 5, 16, 16, 1};
      int lat;
      for (int i = 0; i < 5; i++) begin
         do_req(2'b00, vals[i], lat);
         checks++;
         if (lat != lats[i]) begin errors++; $display("FAIL rot_lat[%0d] got %0d want %0d", i, lat, lats[i]); end
         checks++;
         if (resp_field !== flds[i]) begin errors++; $display("FAIL rot_field[%0d] got %h want %h", i, resp_field, flds[i]); end
         checks++;
         if (resp_ok !== oks[i]) begin errors++; $display("FAIL rot_ok[%0d] got %b want %b", i, resp_ok, oks[i]); end
         checks++;
         if (resp_immsrc !== 2'b00) begin errors++; $display("FAIL rot_immsrc[%0d] got %b want 00", i, resp_immsrc); end
         take_resp();
      end
   endtask

   task automatic test_branch();
      logic [31:0] vals [4] = '{32'hFFFF_FFF8, 32'h0000_0006, 32'h0200_0000, 32'h01FF_FFFC};
      logic [23:0] flds [4] = '{24'hFFFFFE, 24'h000000, 24'h000000, 24'h7FFFFF};
      logic        oks  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int lat;
      for (int i = 0; i < 4; i++) begin
         do_req(2'b10, vals[i], lat);
         checks++;
         if (lat != 1) begin errors++; $display("FAIL br_lat[%0d] got %0d want 1", i, lat); end
         checks++;
         if (resp_field !== flds[i]) begin errors++; $display("FAIL br_field[%0d] got %h want %h", i, resp_field, flds[i]); end
         checks++;
         if (resp_ok !== oks[i]) begin errors++; $display("FAIL br_ok[%0d] got %b want %b", i, resp_ok, oks[i]); end
         checks++;
         if (resp_immsrc !== 2'b10) begin errors++; $display("FAIL br_immsrc[%0d] got %b want 10", i, resp_immsrc); end
         take_resp();
      end
   endtask

   task automatic test_unsigned_reserved();
      logic [1:0]  clss [3] = '{2'b01, 2'b01, 2'b11};
      logic [31:0] vals [3] = '{32'h0000_0FFF, 32'h0000_1000, 32'h0000_0010};
      logic [23:0] flds [3] = '{24'h000FFF, 24'h000000, 24'h000000};
      logic        oks  [3] = '{1'b1, 1'b0, 1'b0};
      int lat;
      for (int i = 0; i < 3; i++) begin
         do_req(clss[i], vals[i], lat);
         checks++;
         if (lat != 1) begin errors++; $display("FAIL ur_lat[%0d] got %0d want 1", i, lat); end
         checks++;
         if (resp_field !== flds[i]) begin errors++; $display("FAIL ur_field[%0d] got %h want %h", i, resp_field, flds[i]); end
         checks++;
         if (resp_ok !== oks[i]) begin errors++; $display("FAIL ur_ok[%0d] got %b want %b", i, resp_ok, oks[i]); end
         checks++;
         if (resp_immsrc !== clss[i]) begin errors++; $display("FAIL ur_immsrc[%0d] got %b want %b", i, resp_immsrc, clss[i]); end
         take_resp();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      do_req(2'b01, 32'h0000_0123, lat);
      req_valid  = 1'b1;
      req_immsrc = 2'b00;
      req_value  = 32'h0000_00FF;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (resp_valid !== 1'b1 || resp_field !== 24'h000123 || resp_ok !== 1'b1 || resp_immsrc !== 2'b01)
            begin errors++; $display("FAIL bp_hold[%0d] got v=%b f=%h ok=%b c=%b want v=1 f=000123 ok=1 c=01", i, resp_valid, resp_field, resp_ok, resp_immsrc); end
         checks++;
         if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0", i, req_ready); end
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL bp_exit got rdy=%b v=%b want rdy=1 v=0", req_ready, resp_valid); end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_accept got rdy=%b want 0", req_ready); end
      @(posedge clk);
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_field !== 24'h0000FF || resp_ok !== 1'b1 || resp_immsrc !== 2'b00)
         begin errors++; $display("FAIL bp_next got v=%b f=%h ok=%b c=%b want v=1 f=0000ff ok=1 c=00", resp_valid, resp_field, resp_ok, resp_immsrc); end
      take_resp();
   endtask

   task automatic test_early_ready();
      int lat;
      resp_ready = 1'b1;
      do_req(2'b01, 32'h0000_0005, lat);
      checks++;
      if (lat != 1 || resp_field !== 24'h000005) begin errors++; $display("FAIL early_resp got lat=%0d f=%h want lat=1 f=000005", lat, resp_field); end
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL early_exit got v=%b rdy=%b want v=0 rdy=1", resp_valid, req_ready); end
   endtask

   task automatic test_reset_midsearch();
      int lat;
      req_valid  = 1'b1;
      req_immsrc = 2'b00;
      req_value  = 32'h0000_0101;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_async got v=%b rdy=%b want v=0 rdy=1", resp_valid, req_ready); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_stale got v=%b want 0", resp_valid); end
      do_req(2'b00, 32'h0000_00FF, lat);
      checks++;
      if (lat != 1 || resp_field !== 24'h0000FF || resp_ok !== 1'b1)
         begin errors++; $display("FAIL rst_after got lat=%0d f=%h ok=%b want lat=1 f=0000ff ok=1", lat, resp_field, resp_ok); end
      take_resp();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_immsrc = 2'b00;
      req_value  = 32'd0;
      resp_ready = 1'b0;
      #2;
      test_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      test_rotated();
      test_branch();
      test_unsigned_reserved();
      test_backpressure();
      test_early_ready();
      test_reset_midsearch();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
